seg7_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the board's common-anode 7-segment bank. It latches a packed hex word plus per-digit decimal-point and enable masks through a valid/ready load port. It drives one digit at a time with a blanking interval between digits to suppress ghosting. It is the sequencer that feeds the hex-to-segment decoder. Outputs connect directly to the anode and cathode pins.

---
 rtl/seg7_pkg.sv | 31 +++
 rtl/hex_to_seg7.sv | 32 +++
 rtl/seg7_scan_ctrl.sv | 128 ++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared segment patterns, anode idle value and scan phase type
package seg7_pkg;

    // Active-low cathode patterns, dp bit (7) held off
    localparam logic [7:0] SEG_0   = 8'hC0;
    localparam logic [7:0] SEG_1   = 8'hF9;
    localparam logic [7:0] SEG_2   = 8'hA4;
    localparam logic [7:0] SEG_3   = 8'hB0;
    localparam logic [7:0] SEG_4   = 8'h99;
    localparam logic [7:0] SEG_5   = 8'h92;
    localparam logic [7:0] SEG_6   = 8'h82;
    localparam logic [7:0] SEG_7   = 8'hF8;
    localparam logic [7:0] SEG_8   = 8'h80;
    localparam logic [7:0] SEG_9   = 8'h98;
    localparam logic [7:0] SEG_A   = 8'h88;
    localparam logic [7:0] SEG_B   = 8'h83;
    localparam logic [7:0] SEG_C   = 8'hC6;
    localparam logic [7:0] SEG_D   = 8'hA1;
    localparam logic [7:0] SEG_E   = 8'h86;
    localparam logic [7:0] SEG_F   = 8'h8E;
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Wide enough for the largest bank; sliced down to DIGITS at the use site
    localparam logic [7:0] ANODE_OFF = 8'hFF;

    typedef enum logic {
        PH_BLANK,
        PH_SHOW
    } phase_e;

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - hex nibble to active-low 7-segment pattern (g..a)
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF[6:0];
        case (hex)
            4'h0:    seg = SEG_0[6:0];
            4'h1:    seg = SEG_1[6:0];
            4'h2:    seg = SEG_2[6:0];
            4'h3:    seg = SEG_3[6:0];
            4'h4:    seg = SEG_4[6:0];
            4'h5:    seg = SEG_5[6:0];
            4'h6:    seg = SEG_6[6:0];
            4'h7:    seg = SEG_7[6:0];
            4'h8:    seg = SEG_8[6:0];
            4'h9:    seg = SEG_9[6:0];
            4'hA:    seg = SEG_A[6:0];
            4'hB:    seg = SEG_B[6:0];
            4'hC:    seg = SEG_C[6:0];
            4'hD:    seg = SEG_D[6:0];
            4'hE:    seg = SEG_E[6:0];
            4'hF:    seg = SEG_F[6:0];
            default: seg = SEG_OFF[6:0];
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - time-multiplexed scan sequencer for a common-anode 7-segment bank
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DIGITS = 8,
    parameter int DIV    = 100000,
    parameter int BLANK  = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     en_in,
    input  logic                  load_valid,
    output logic                  load_ready,
    output logic [DIGITS-1:0]     an,
    output logic [7:0]            seg,
    output logic                  frame_done
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    logic [CW-1:0]          cnt;
    logic [IW-1:0]          idx;

    logic [4*DIGITS-1:0]    pending_data;
    logic [DIGITS-1:0]      pending_dp;
    logic [DIGITS-1:0]      pending_en;
    logic                   pending_full;

    logic [4*DIGITS-1:0]    shadow_data;
    logic [DIGITS-1:0]      shadow_dp;
    logic [DIGITS-1:0]      shadow_en;

    logic                   slot_end;
    logic                   frame_end;
    logic                   load_fire;
    phase_e                 phase;
    logic [3:0]             nibble;
    logic [6:0]             glyph;
    logic [DIGITS-1:0]      an_next;
    logic [7:0]             seg_next;

    assign load_ready = ~pending_full;

    always_comb begin
        slot_end  = (cnt == CNT_LAST);
        frame_end = slot_end && (idx == IDX_LAST);
        load_fire = load_valid && !pending_full;
        phase     = (cnt < CNT_BLANK) ? PH_BLANK : PH_SHOW;
        nibble    = shadow_data[{idx, 2'b00} +: 4];
    end

    hex_to_seg7 u_hex_to_seg7 (
        .hex (nibble),
        .seg (glyph)
    );

    // Next-cycle pin values; registered below so an/seg lag cnt/idx by one cycle
    always_comb begin
        an_next  = ANODE_OFF[DIGITS-1:0];
        seg_next = SEG_OFF;
        if (phase == PH_SHOW && shadow_en[idx]) begin
            an_next  = ~(DIGITS'(1) << idx);
            seg_next = {~shadow_dp[idx], glyph};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            if (slot_end) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Shadow only changes at a frame boundary, so a frame is never torn;
    // a load accepted on the boundary itself waits for the following one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_data <= '0;
            pending_dp   <= '0;
            pending_en   <= '0;
            pending_full <= 1'b0;
            shadow_data  <= '0;
            shadow_dp    <= '0;
            shadow_en    <= '0;
        end else begin
            if (frame_end && pending_full) begin
                shadow_data <= pending_data;
                shadow_dp   <= pending_dp;
                shadow_en   <= pending_en;
            end
            if (load_fire) begin
                pending_data <= data_in;
                pending_dp   <= dp_in;
                pending_en   <= en_in;
                pending_full <= 1'b1;
            end else if (frame_end) begin
                pending_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an         <= ANODE_OFF[DIGITS-1:0];
            seg        <= SEG_OFF;
            frame_done <= 1'b0;
        end else begin
            an         <= an_next;
            seg        <= seg_next;
            frame_done <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - self-checking bench for seg7_scan_ctrl against a time-indexed reference model
module tb_seg7_scan_ctrl;

    localparam int DIGITS = 4;
    localparam int DIV    = 8;
    localparam int BLANK  = 2;
    localparam int FRAME  = DIGITS * DIV;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic [3:0]  en_in;
    logic        load_valid;
    logic        load_ready;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        frame_done;

    seg7_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV), .BLANK(BLANK)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .en_in      (en_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .an         (an),
        .seg        (seg),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] glyph_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                   8'h80, 8'h98, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Model: t counts clock edges since reset release; slot/digit derive from it.
    int          t;
    logic        m_pf;
    logic [15:0] m_pd, m_sd;
    logic [3:0]  m_pdp, m_sdp, m_pen, m_sen;
    logic        m_fire;

    int          cnt_lit;
    int          cnt_watch;
    logic [7:0]  watch_seg;

    logic [3:0]  rec_an  [1:FRAME];
    logic [7:0]  rec_seg [1:FRAME];
    logic        rec_fd  [1:FRAME];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        int         slot, digit;
        logic       bnd;
        logic [3:0] e_an;
        logic [7:0] e_seg, g;
        logic       e_fd;
        bnd   = 1'b0;
        e_an  = 4'hF;
        e_seg = 8'hFF;
        e_fd  = 1'b0;
        m_fire = 1'b0;
        if (rst_n) begin
            slot  = t % DIV;
            digit = (t / DIV) % DIGITS;
            bnd   = (slot == DIV - 1) && (digit == DIGITS - 1);
            if (slot >= BLANK && m_sen[digit]) begin
                g     = glyph_tab[m_sd[digit*4 +: 4]];
                e_an  = 4'hF & ~(4'd1 << digit);
                e_seg = {~m_sdp[digit], g[6:0]};
            end
            e_fd   = bnd;
            m_fire = load_valid && !m_pf;
        end
        @(posedge clk);
        if (!rst_n) begin
            t = 0; m_pf = 0;
            m_pd = '0; m_sd = '0; m_pdp = '0; m_sdp = '0; m_pen = '0; m_sen = '0;
        end else begin
            if (bnd && m_pf) begin
                m_sd = m_pd; m_sdp = m_pdp; m_sen = m_pen; m_pf = 1'b0;
            end
            if (m_fire) begin
                m_pd = data_in; m_pdp = dp_in; m_pen = en_in; m_pf = 1'b1;
            end
            t++;
        end
        @(negedge clk);
        check("an", an, e_an);
        check("seg", seg, e_seg);
        check("frame_done", frame_done, e_fd);
        check("load_ready", load_ready, !m_pf);
        if (an != 4'hF) cnt_lit++;
        if (seg == watch_seg) cnt_watch++;
    endtask

    task automatic load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en);
        logic done;
        done = 1'b0;
        data_in = d; dp_in = dp; en_in = en; load_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            step();
            done = m_fire;
        end
        load_valid = 1'b0;
        check("load_accept", done, 1'b1);
    endtask

    task automatic wait_frame();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            step();
            seen = frame_done;
        end
        check("frame_wait", seen, 1'b1);
    endtask

    task automatic record_frame();
        for (int k = 1; k <= FRAME; k++) begin
            step();
            rec_an[k]  = an;
            rec_seg[k] = seg;
            rec_fd[k]  = frame_done;
        end
    endtask

    initial begin
        logic [3:0] exp_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [7:0] exp_seg [4] = '{8'h0E, 8'hC0, 8'h88, 8'hB0};
        int   active, fds, lit13, lit0, lit2, waited;
        logic prev_fd, done;

        rst_n = 1'b0; data_in = '0; dp_in = '0; en_in = '0; load_valid = 1'b0;
        watch_seg = 8'h00; cnt_lit = 0; cnt_watch = 0; t = 0; m_pf = 0;
        m_pd = '0; m_sd = '0; m_pdp = '0; m_sdp = '0; m_pen = '0; m_sen = '0;

        // 1: reset then two dark frames
        repeat (3) step();
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 8'hFF);
        check("rst_ready", load_ready, 1'b1);
        check("rst_fd", frame_done, 1'b0);
        rst_n = 1'b1;
        cnt_lit = 0;
        repeat (2 * FRAME) step();
        check("dark_no_load", cnt_lit, 0);

        // 2 and 3: pattern and slot timing
        load(16'h3A0F, 4'b0001, 4'hF);
        wait_frame();
        record_frame();
        fds = 0;
        for (int d = 0; d < DIGITS; d++) begin
            active = 0;
            for (int k = 8*d + 1; k <= 8*d + 8; k++) if (rec_an[k] != 4'hF) active++;
            check($sformatf("slot_active_%0d", d), active, 6);
            check($sformatf("slot_blank_%0d", d), rec_an[8*d + 2], 4'hF);
            check($sformatf("digit_an_%0d", d), rec_an[8*d + 3], exp_an[d]);
            check($sformatf("digit_seg_%0d", d), rec_seg[8*d + 5], exp_seg[d]);
        end
        for (int k = 1; k <= FRAME; k++) if (rec_fd[k]) fds++;
        check("fd_count", fds, 1);
        check("fd_position", rec_fd[FRAME], 1'b1);

        // 4: back-to-back loads
        watch_seg = 8'hF9; cnt_watch = 0;
        load(16'h1111, 4'h0, 4'hF);
        check("b2b_ready_drop", load_ready, 1'b0);
        data_in = 16'h2222; load_valid = 1'b1; done = 1'b0; waited = 0;
        prev_fd = frame_done;
        while (!done && waited < 200) begin
            prev_fd = frame_done;
            step();
            done = m_fire;
            waited++;
        end
        load_valid = 1'b0;
        check("b2b_accept", done, 1'b1);
        check("b2b_after_boundary", prev_fd, 1'b1);
        wait_frame();
        wait_frame();
        check("b2b_one_frame_1111", cnt_watch, 24);

        // 5: load accepted on the boundary cycle
        waited = 0;
        while ((t % FRAME) != FRAME - 1 && waited < 100) begin step(); waited++; end
        check("bnd_align", t % FRAME, FRAME - 1);
        data_in = 16'h5555; dp_in = 4'h0; en_in = 4'hF; load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        check("bnd_accept", m_fire, 1'b1);
        check("bnd_fd", frame_done, 1'b1);
        check("bnd_ready", load_ready, 1'b0);
        watch_seg = 8'h92; cnt_watch = 0;
        repeat (FRAME) step();
        check("bnd_not_in_start_frame", cnt_watch, 0);
        cnt_watch = 0;
        repeat (FRAME) step();
        check("bnd_next_frame", cnt_watch, 24);

        // 6: partial enable mask, then reset with a load pending
        load(16'h4321, 4'b1111, 4'b0101);
        wait_frame();
        wait_frame();
        lit13 = 0; lit0 = 0; lit2 = 0;
        for (int k = 0; k < FRAME; k++) begin
            step();
            if (!an[1] || !an[3]) lit13++;
            if (an == 4'b1110) lit0++;
            if (an == 4'b1011) lit2++;
        end
        check("mask_dark_13", lit13, 0);
        check("mask_lit_0", lit0, 6);
        check("mask_lit_2", lit2, 6);
        load(16'hFFFF, 4'hF, 4'hF);
        repeat (3) step();
        rst_n = 1'b0;
        step();
        check("midrst_an", an, 4'hF);
        check("midrst_seg", seg, 8'hFF);
        check("midrst_ready", load_ready, 1'b1);
        check("midrst_fd", frame_done, 1'b0);
        rst_n = 1'b1;
        cnt_lit = 0;
        repeat (2 * FRAME + 2) step();
        check("midrst_pending_dropped", cnt_lit, 0);

        // Randomized traffic; requester holds data until accepted
        for (int i = 0; i < 3000; i++) begin
            if (load_valid && m_fire) load_valid = 1'b0;
            if (!load_valid && $urandom_range(0, 19) == 0) begin
                data_in = 16'($urandom);
                dp_in = 4'($urandom);
                en_in = 4'($urandom);
                load_valid = 1'b1;
            end
            rst_n = ($urandom_range(0, 599) != 0);
            step();
        end
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
